// File: rtl/mult_mem_reader.sv
// Consumer end of the 8-word multiplier result memory: counts completed half-fills,
// snapshots all 8 words, streams them over valid/ready and reports their wrap-around sum.
module mult_mem_reader #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_in,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  input  logic [WIDTH-1:0] in8,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_idx,
  output logic             out_last,
  output logic [WIDTH-1:0] sum,
  output logic             sum_valid,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             we_q, we_d;
  logic [1:0]       half_cnt_q, half_cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [WIDTH-1:0] sum_acc_q, sum_acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] buf_q [8];
  logic [WIDTH-1:0] buf_d [8];
  logic [WIDTH-1:0] in_words [8];

  logic             fall;
  logic             capture;
  logic             fire;
  logic [WIDTH-1:0] acc_next;

  assign in_words[0] = in1;
  assign in_words[1] = in2;
  assign in_words[2] = in3;
  assign in_words[3] = in4;
  assign in_words[4] = in5;
  assign in_words[5] = in6;
  assign in_words[6] = in7;
  assign in_words[7] = in8;

  // A completed half-fill is the falling edge of the write strobe.
  assign fall     = we_q & ~we_in;
  assign capture  = (state_q == S_IDLE) &&
                    ((half_cnt_q == 2'd2) || ((half_cnt_q == 2'd1) && fall));
  assign fire     = (state_q == S_STREAM) && out_ready;
  assign acc_next = sum_acc_q + buf_q[idx_q];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (capture) state_d = S_STREAM;
      S_STREAM: if (fire && (idx_q == 3'd7)) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    // NOTE: every variable gets a hold value first so no path through this block
    // leaves it unassigned, which would otherwise infer a latch.
    we_d       = we_in;
    half_cnt_d = half_cnt_q;
    idx_d      = idx_q;
    sum_acc_d  = sum_acc_q;
    sum_d      = sum_q;
    overrun_d  = overrun_q;
    buf_d      = buf_q;

    if (capture) begin
      // A fall at the capture edge only survives when it is a third half on top of a stored pair.
      half_cnt_d = ((half_cnt_q == 2'd2) && fall) ? 2'd1 : 2'd0;
      buf_d      = in_words;
      idx_d      = 3'd0;
      sum_acc_d  = '0;
    end else if (fall) begin
      if (half_cnt_q == 2'd2) begin
        overrun_d = 1'b1;
      end else begin
        half_cnt_d = half_cnt_q + 2'd1;
      end
    end

    if (fire) begin
      sum_acc_d = acc_next;
      if (idx_q == 3'd7) begin
        sum_d = acc_next;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of evaluation order.
    if (rst) begin
      we_q       <= 1'b0;
      half_cnt_q <= 2'd0;
      idx_q      <= 3'd0;
      sum_acc_q  <= '0;
      sum_q      <= '0;
      overrun_q  <= 1'b0;
      // NOTE: the snapshot buffer is reset as well so out_data is never undefined
      // after reset; it is only 8 words, so the reset fan-out is acceptable.
      for (int i = 0; i < 8; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      we_q       <= we_d;
      half_cnt_q <= half_cnt_d;
      idx_q      <= idx_d;
      sum_acc_q  <= sum_acc_d;
      sum_q      <= sum_d;
      overrun_q  <= overrun_d;
      buf_q      <= buf_d;
    end
  end

  // Output logic; stream fields read zero outside STREAM.
  always_comb begin
    out_valid = (state_q == S_STREAM);
    out_data  = out_valid ? buf_q[idx_q] : '0;
    out_idx   = out_valid ? idx_q : 3'd0;
    out_last  = out_valid && (idx_q == 3'd7);
    sum_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    sum       = sum_q;
    overrun   = overrun_q;
  end

endmodule

// File: doc/mult_mem_reader.md
Name: mult_mem_reader

Overview:
- Consumer end of the 8-word multiplier result memory.
- Monitors the same write strobe that fills the memory. One write burst fills 4 words (one half). After two completed bursts, it snapshots all 8 words into a local buffer.
- Streams the buffered words to the next stage, one per cycle, over a valid/ready handshake. Also produces the wrap-around sum of the 8 words (vector reduction).
- Sits between the result memory and the vector writeback/store stage.

Parameters:
- WIDTH, 32, bit width of each data word and of the sum.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- we_in  input  1  copy of the memory write enable; each high→low transition marks one completed half-fill.
- in1..in8  input  WIDTH each  memory words 0..7.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_valid  output  1  out_data/out_idx/out_last are valid.
- out_data  output  WIDTH  current buffered word.
- out_idx  output  3  index 0..7 of out_data.
- out_last  output  1  high with word 7.
- sum  output  WIDTH  sum of the last streamed vector; holds until the next DONE.
- sum_valid  output  1  one-cycle pulse when sum updates.
- busy  output  1  high in STREAM or DONE.
- overrun  output  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset (rst=1 at a posedge):
  - State = IDLE.
  - we_d = 0, half_cnt = 0, idx = 0, sum_acc = 0, buffer = 0.
  - All outputs = 0.
  - Reset mid-stream aborts the stream with no sum_valid pulse.
- Fall detect:
  - we_d is registered we_in.
  - fall = we_d & ~we_in, evaluated at each posedge.
  - A pulse that is high for exactly one cycle counts once. No counting on rising edges.
- half_cnt (2 bits, 0..2):
  - Increments on fall in every state.
  - If half_cnt==2, the vector is not yet consumed, and fall occurs: overrun←1 and half_cnt stays 2.
- IDLE:
  - Entered when half_cnt==2, or when half_cnt==1 and fall occurs.
  - At that edge: buffer[i]←in(i+1) for all 8 words, idx←0, sum_acc←0, state←STREAM.
  - half_cnt←0 at that edge; it becomes 1 if fall occurs at the same edge as a capture made from an already-stored count of 2.
  - Latency: out_valid is high in the cycle right after the capturing edge.
- STREAM:
  - out_valid=1, out_data=buffer[idx], out_idx=idx, out_last=(idx==7).
  - Outputs are stable while out_ready=0.
  - On out_valid&out_ready: sum_acc←sum_acc+out_data, modulo 2^WIDTH with carry discarded.
  - Then idx==7 → state DONE; otherwise idx←idx+1.
  - Minimum 8 cycles with out_ready held at 1.
- DONE (one cycle):
  - sum←sum_acc and sum_valid=1 for this cycle.
  - out_valid=0; state←IDLE.
  - The next capture can occur at the edge that leaves IDLE on the following cycle, at the earliest.
- Snapshot isolation: memory writes during STREAM/DONE do not affect the streamed data. They only advance half_cnt.
- busy = (state != IDLE).

Test Plan:
- Basic: reset; preload in1..in8 = 1..8; two 1-cycle we_in pulses 3 cycles apart; out_ready=1 → out_valid rises 1 cycle after the 2nd fall is detected; out_data 1..8 on 8 consecutive cycles with out_idx 0..7; out_last only on 8; next cycle sum=36 with sum_valid for 1 cycle.
- Backpressure: same data; out_ready toggled 1,0,0,1,… → each word held stable while out_ready=0; no skipped or duplicated idx; sum=36.
- Wrap: in1..in8 = 0xFFFFFFFF each → sum=0xFFFFFFF8; no extra flags.
- Long pulse / single half: we_in high 5 cycles, then low, once → half_cnt=1, no stream; 2nd pulse → stream starts.
- Overrun: during STREAM, issue 3 we_in pulses → overrun=1 sticky; after DONE, an immediate new capture uses current in1..in8.
- Reset mid-stream: rst after 3 handshakes → all outputs 0, no sum_valid; two new pulses → stream restarts at idx 0 and the sum excludes pre-reset words.
